ezm_prog_feeder: RTL and testbench
==================================

EZM_PROG_FEEDER -- requirements
Module: ezm_prog_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 16, sets the program-store depth in 6-bit instructions; legal values are powers of two from 2 to 64.
REQ-003 Parameter LOOP, default 0; 1 restarts playback at address 0 after the last instruction, 0 stops after one pass.
REQ-004 clk  input  1  rising-edge clock; the same clock as the downstream CPU.
REQ-005 rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-006 wr_valid  input  1  an instruction is offered on wr_data.
REQ-007 wr_data  input  6  instruction word to append to the program store.
REQ-008 wr_ready  output  1  the store accepts a write this cycle.
REQ-009 start  input  1  begin playback of the stored program.
REQ-010 stop  input  1  abort playback.
REQ-011 clear  input  1  empty the program store.
REQ-012 instr_o  output  6  registered instruction word driving the CPU in_i input.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  high while in DONE.
REQ-015 count_o  output  log2(DEPTH)+1  number of stored instructions.

Function
REQ-016 The state machine SHALL have exactly three states, IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE).
REQ-017 wr_ready SHALL equal (state==IDLE) && (count<DEPTH) && !start && !clear.
- It is combinational.
REQ-018 When wr_valid && wr_ready is true at an edge, the block SHALL write mem[count] <= wr_data and increment count.
REQ-019 When count==DEPTH (full), wr_ready SHALL be 0, wr_valid SHALL be ignored, and count SHALL never exceed DEPTH.
REQ-020 In IDLE, clear SHALL set count to 0 at the next edge; memory contents need not be erased.
REQ-021 In IDLE, start with count>0 SHALL move the block to RUN at the next edge.
- On that same edge: instr_o <= mem[0] and rd_ptr <= 1.
REQ-022 In IDLE, start with count==0 SHALL be ignored.
REQ-023 On each RUN edge with rd_ptr<count, the block SHALL set instr_o <= mem[rd_ptr] and increment rd_ptr.
- Result: exactly one instruction per clock, in address order.
REQ-024 On a RUN edge with rd_ptr==count:
- LOOP=0: instr_o <= 6'b000000 and the state moves to DONE.
- LOOP=1: instr_o <= mem[0] and rd_ptr <= 1, with no NOP bubble.
REQ-025 In RUN, stop SHALL take priority over every other condition.
- At the next edge: instr_o <= 0, rd_ptr <= 0, state goes to IDLE.
- The stored program and count SHALL be retained.
REQ-026 clear and wr_valid SHALL be ignored in RUN.
REQ-027 In DONE:
- start SHALL replay the program exactly as in REQ-021.
- clear SHALL set count to 0 and go to IDLE.
- stop SHALL go to IDLE.
- Priority is stop > clear > start.
REQ-028 In IDLE, clear SHALL take priority over start.
REQ-029 instr_o SHALL be 6'b000000 (CPU no-op) in every cycle the block is not in RUN.
REQ-030 Counter widths SHALL be log2(DEPTH)+1 bits so that count==DEPTH is representable; rd_ptr SHALL never index past DEPTH-1.

Reset
REQ-031 While rst==0, asynchronously and regardless of clk, the block SHALL force:
- state=IDLE, count=0, rd_ptr=0;
- instr_o=0, busy=0, done=0;
- wr_ready=0 while rst is held low.
REQ-032 Reset asserted mid-RUN SHALL abort playback immediately; after release the block SHALL behave as empty (count_o=0).
REQ-033 Memory contents are not reset and SHALL NOT be observable until rewritten.

Verification
REQ-034 Load and play: write 0x21, 0x09, 0x11, then pulse start.
- instr_o reads 0x21, 0x09, 0x11 on three consecutive cycles, then 0x00.
- done=1 from the fourth cycle after the start edge.
REQ-035 Full: with DEPTH=16, hold wr_valid for 20 cycles.
- Exactly 16 writes are accepted, count_o=16, wr_ready=0 from the cycle after the 16th write.
REQ-036 Loop: with LOOP=1 and program 0x3F, 0x01, hold start for one cycle.
- instr_o sequence is 0x3F, 0x01, 0x3F, 0x01, ... with no 0x00 gap.
- stop then gives instr_o=0x00 and busy=0 one edge later, with count_o still 2.
REQ-037 Priority and empty start:
- start with count=0 leaves the block in IDLE with instr_o=0.
- clear and start in the same cycle with count=5 gives count_o=0 and the block stays in IDLE.
REQ-038 Reset mid-run: drive rst=0 between clock edges during RUN.
- instr_o=0 and busy=0 immediately, before the next edge.
- After release, count_o=0 and wr_ready=1.

Source files
------------

// File: rtl/ezm_prog_feeder.sv
`default_nettype none
// ============================================================================
// Module  : ezm_prog_feeder
// Brief   : Small program store that is loaded one 6-bit instruction at a
//           time and then replayed, one instruction per clock, into the
//           in_i input of a downstream CPU. It emits a no-op (6'b000000)
//           whenever it is not playing.
// Revision: 1.0 - initial release
// ============================================================================
module ezm_prog_feeder #(
    parameter int DEPTH = 16,   // program-store depth, power of two in 2..64
    parameter int LOOP  = 0     // 1: wrap to address 0 after the last word
) (
    input  logic                     clk,
    input  logic                     rst,       // asynchronous, active-low
    input  logic                     wr_valid,
    input  logic [5:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    output logic [5:0]               instr_o,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam int             c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic [5:0]     c_NOP   = 6'b000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [c_CW-1:0]   count_q;     // number of stored words, may equal DEPTH
    logic [c_CW-1:0]   rd_ptr_q;    // next address to play
    logic [5:0]        instr_q;
    logic [5:0]        mem_q [DEPTH];

    logic              wr_fire;
    logic [5:0]        rd_word;
    logic [5:0]        first_word;

    // Writes are only accepted while idle, not full, and with no competing
    // start/clear request; rst gating keeps wr_ready low during reset.
    always_comb begin
        wr_ready = rst && (state_q == S_IDLE) && (count_q < c_DEPTH)
                   && !start && !clear;
        wr_fire  = wr_valid && wr_ready;
    end

    // Read ports: rd_ptr is only used while rd_ptr < count <= DEPTH, so the
    // low address bits always select a valid entry.
    always_comb begin
        rd_word    = mem_q[rd_ptr_q[c_AW-1:0]];
        first_word = mem_q[0];
    end

    // Program store: no reset so it maps onto plain RAM; stale contents are
    // unreachable because count restarts at zero.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[count_q[c_AW-1:0]] <= wr_data;
        end
    end

    // Control FSM with registered instruction output and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            instr_q  <= c_NOP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    instr_q <= c_NOP;
                    if (clear) begin
                        count_q <= '0;
                    end else if (start && (count_q != '0)) begin
                        state_q  <= S_RUN;
                        instr_q  <= first_word;
                        rd_ptr_q <= c_ONE;
                    end else if (wr_fire) begin
                        count_q <= count_q + c_ONE;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q  <= S_IDLE;
                        instr_q  <= c_NOP;
                        rd_ptr_q <= '0;
                    end else if (rd_ptr_q < count_q) begin
                        instr_q  <= rd_word;
                        rd_ptr_q <= rd_ptr_q + c_ONE;
                    end else if (LOOP != 0) begin
                        // wrap without inserting a no-op bubble
                        instr_q  <= first_word;
                        rd_ptr_q <= c_ONE;
                    end else begin
                        state_q  <= S_DONE;
                        instr_q  <= c_NOP;
                        rd_ptr_q <= '0;
                    end
                end
                S_DONE: begin
                    instr_q <= c_NOP;
                    if (stop) begin
                        state_q <= S_IDLE;
                    end else if (clear) begin
                        state_q <= S_IDLE;
                        count_q <= '0;
                    end else if (start) begin
                        state_q  <= S_RUN;
                        instr_q  <= first_word;
                        rd_ptr_q <= c_ONE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    instr_q  <= c_NOP;
                    rd_ptr_q <= '0;
                end
            endcase
        end
    end

    // Status outputs are straight decodes of registered state.
    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        instr_o = instr_q;
        count_o = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ezm_prog_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ezm_prog_feeder
// Brief   : Directed self-checking bench; dut0 plays once, dut1 loops.
//           Both share the same stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ezm_prog_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [5:0] wr_data;
    logic       start;
    logic       stop;
    logic       clear;

    logic       wr_ready0, busy0, done0;
    logic [5:0] instr0;
    logic [4:0] count0;
    logic       wr_ready1, busy1, done1;
    logic [5:0] instr1;
    logic [4:0] count1;

    int checks = 0;
    int errors = 0;

    ezm_prog_feeder #(.DEPTH(16), .LOOP(0)) dut0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready0), .start(start), .stop(stop), .clear(clear),
        .instr_o(instr0), .busy(busy0), .done(done0), .count_o(count0)
    );

    ezm_prog_feeder #(.DEPTH(16), .LOOP(1)) dut1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready1), .start(start), .stop(stop), .clear(clear),
        .instr_o(instr1), .busy(busy1), .done(done1), .count_o(count1)
    );

    always #5 clk = ~clk;

    // advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic go_idle_empty();
        stop = 1'b1; tick(); stop = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_valid = 0; wr_data = 0; start = 0; stop = 0; clear = 0;
        #12;
        checks++; if (instr0 !== 6'h00) begin errors++; $display("FAIL reset_instr got %h want 00", instr0); end
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b done=%b want 0 0", busy0, done0); end
        checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count0); end
        checks++; if (wr_ready0 !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready0); end
        rst = 1'b1;
        tick();
        checks++; if (wr_ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready got %b want 1", wr_ready0); end
    endtask

    task automatic test_load_play();
        logic [5:0] exp [3];
        exp[0] = 6'h21; exp[1] = 6'h09; exp[2] = 6'h11;
        for (int i = 0; i < 3; i++) push(exp[i]);
        checks++; if (count0 !== 5'd3) begin errors++; $display("FAIL load_count got %0d want 3", count0); end
        start = 1'b1;
        #1;
        checks++; if (wr_ready0 !== 1'b0) begin errors++; $display("FAIL start_blocks_wr got %b want 0", wr_ready0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            checks++; if (instr0 !== exp[i] || busy0 !== 1'b1) begin errors++; $display("FAIL play_word%0d got %h busy=%b want %h busy=1", i, instr0, busy0, exp[i]); end
        end
        tick();
        checks++; if (instr0 !== 6'h00 || done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL play_end got %h done=%b busy=%b want 00 1 0", instr0, done0, busy0); end
        checks++; if (instr1 !== 6'h21 || busy1 !== 1'b1) begin errors++; $display("FAIL loop_wrap3 got %h busy=%b want 21 1", instr1, busy1); end
        tick();
        checks++; if (instr0 !== 6'h00 || done0 !== 1'b1) begin errors++; $display("FAIL done_hold got %h done=%b want 00 1", instr0, done0); end
        // replay from DONE
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (instr0 !== 6'h21 || busy0 !== 1'b1) begin errors++; $display("FAIL replay got %h busy=%b want 21 1", instr0, busy0); end
        go_idle_empty();
        checks++; if (count0 !== 5'd0 || count1 !== 5'd0) begin errors++; $display("FAIL clear_after_play got %0d/%0d want 0", count0, count1); end
    endtask

    task automatic test_full();
        wr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = 6'(i + 1);
            tick();
            if (i == 14) begin
                checks++; if (wr_ready0 !== 1'b1 || count0 !== 5'd15) begin errors++; $display("FAIL near_full got rdy=%b cnt=%0d want 1 15", wr_ready0, count0); end
            end
            if (i == 15) begin
                checks++; if (wr_ready0 !== 1'b0 || count0 !== 5'd16) begin errors++; $display("FAIL full got rdy=%b cnt=%0d want 0 16", wr_ready0, count0); end
            end
        end
        wr_valid = 1'b0;
        checks++; if (count0 !== 5'd16 || wr_ready0 !== 1'b0) begin errors++; $display("FAIL full_hold got cnt=%0d rdy=%b want 16 0", count0, wr_ready0); end
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            start = 1'b0;
            checks++; if (instr0 !== 6'(k + 1)) begin errors++; $display("FAIL full_play%0d got %h want %h", k, instr0, 6'(k + 1)); end
        end
        tick();
        checks++; if (instr0 !== 6'h00 || done0 !== 1'b1) begin errors++; $display("FAIL full_end got %h done=%b want 00 1", instr0, done0); end
        go_idle_empty();
    endtask

    task automatic test_loop();
        logic [5:0] exp [5];
        exp[0] = 6'h3F; exp[1] = 6'h01; exp[2] = 6'h3F; exp[3] = 6'h01; exp[4] = 6'h3F;
        push(6'h3F);
        push(6'h01);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            checks++; if (instr1 !== exp[i] || busy1 !== 1'b1) begin errors++; $display("FAIL loop_word%0d got %h busy=%b want %h 1", i, instr1, busy1, exp[i]); end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (instr1 !== 6'h00 || busy1 !== 1'b0 || count1 !== 5'd2) begin errors++; $display("FAIL loop_stop got %h busy=%b cnt=%0d want 00 0 2", instr1, busy1, count1); end
        tick();
        checks++; if (instr1 !== 6'h00 || done1 !== 1'b0) begin errors++; $display("FAIL stop_idle got %h done=%b want 00 0", instr1, done1); end
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_priority();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || instr0 !== 6'h00) begin errors++; $display("FAIL empty_start got busy=%b done=%b instr=%h want 0 0 00", busy0, done0, instr0); end
        for (int i = 0; i < 5; i++) push(6'(i + 8));
        checks++; if (count0 !== 5'd5) begin errors++; $display("FAIL prio_load got %0d want 5", count0); end
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        checks++; if (count0 !== 5'd0 || busy0 !== 1'b0 || instr0 !== 6'h00) begin errors++; $display("FAIL clear_over_start got cnt=%0d busy=%b instr=%h want 0 0 00", count0, busy0, instr0); end
        // DONE: clear beats start
        push(6'h05);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", done0); end
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        checks++; if (done0 !== 1'b0 || busy0 !== 1'b0 || count0 !== 5'd0) begin errors++; $display("FAIL done_clear got done=%b busy=%b cnt=%0d want 0 0 0", done0, busy0, count0); end
        // RUN: clear and wr_valid ignored
        push(6'h07); push(6'h0A);
        stop = 1'b1; tick(); stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        clear = 1'b1; wr_valid = 1'b1; wr_data = 6'h33; tick(); clear = 1'b0; wr_valid = 1'b0;
        checks++; if (instr0 !== 6'h0A || count0 !== 5'd2 || busy0 !== 1'b1) begin errors++; $display("FAIL run_ignore got %h cnt=%0d busy=%b want 0A 2 1", instr0, count0, busy0); end
        go_idle_empty();
    endtask

    task automatic test_reset_midrun();
        push(6'h21); push(6'h09); push(6'h11);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        checks++; if (instr0 !== 6'h09 || busy0 !== 1'b1) begin errors++; $display("FAIL pre_reset got %h busy=%b want 09 1", instr0, busy0); end
        #2 rst = 1'b0;
        #1;
        checks++; if (instr0 !== 6'h00 || busy0 !== 1'b0 || wr_ready0 !== 1'b0) begin errors++; $display("FAIL async_reset got %h busy=%b rdy=%b want 00 0 0", instr0, busy0, wr_ready0); end
        checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL async_reset_cnt got %0d want 0", count0); end
        tick();
        #2 rst = 1'b1;
        tick();
        checks++; if (count0 !== 5'd0 || wr_ready0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL after_reset got cnt=%0d rdy=%b busy=%b want 0 1 0", count0, wr_ready0, busy0); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (busy0 !== 1'b0 || instr0 !== 6'h00) begin errors++; $display("FAIL stale_mem got busy=%b instr=%h want 0 00", busy0, instr0); end
    endtask

    initial begin
        test_reset();
        test_load_play();
        test_full();
        test_loop();
        test_priority();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
